// File: rtl/cpu_mem_pkg.sv
// Shared constants for the byte-wide memory port: widths, beats per word
// transfer and the arbiter state encoding.
package cpu_mem_pkg;

    localparam int ADDR_W = 32;
    localparam int BYTE_W = 8;
    localparam int BEATS  = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2,
        TURN = 2'd3
    } arb_state_t;

endpackage

// File: rtl/mem_port_arbiter_arb_pick.sv
// arb_pick: combinational two-way arbitration policy.
// Build option ROUND_ROBIN_EN: when defined, a simultaneous request goes to the
// requester that was not granted last (i_last = index of the last owner).
// When undefined, requester 0 (data side) always wins a tie and there is no
// pointer input.
module arb_pick (
    input  logic       i_req0,
    input  logic       i_req1,
`ifdef ROUND_ROBIN_EN
    input  logic       i_last,
`endif
    output logic [1:0] o_pick
);

    // one-hot pick: bit 0 selects requester 0, bit 1 selects requester 1
    always_comb begin
        o_pick = 2'b00;
        if (i_req0 && i_req1) begin
`ifdef ROUND_ROBIN_EN
            o_pick = i_last ? 2'b01 : 2'b10;
`else
            o_pick = 2'b01;
`endif
        end else if (i_req0) begin
            o_pick = 2'b01;
        end else if (i_req1) begin
            o_pick = 2'b10;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares the byte-wide external memory port between the
// data-side (0) and instruction-side (1) cache controllers, one 4-byte word
// transfer per grant, with a one-cycle TURN bubble between owners so MD is
// never driven by two sides back to back.
// Build option ROUND_ROBIN_EN selects round-robin tie breaking (default: fixed,
// requester 0 wins).
module mem_port_arbiter
    import cpu_mem_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_req0,
    input  logic              i_req1,
    input  logic [ADDR_W-1:0] i_addr0,
    input  logic [ADDR_W-1:0] i_addr1,
    input  logic              i_we0,
    input  logic              i_we1,
    input  logic [BYTE_W-1:0] i_wd0,
    input  logic [BYTE_W-1:0] i_wd1,
    output logic              o_gnt0,
    output logic              o_gnt1,
    output logic              o_rdy0,
    output logic              o_rdy1,
    output logic [BYTE_W-1:0] o_rd,
    output logic [ADDR_W-1:0] o_maddr,
    output logic              o_mwe,
    inout  wire  [BYTE_W-1:0] io_md,
    input  logic              i_mrdy
);

    arb_state_t        r_state;
    arb_state_t        w_next;
    logic [1:0]        r_beat;
    logic              r_gnt0;
    logic              r_gnt1;
    logic [ADDR_W-1:0] r_maddr;
    logic [ADDR_W-1:0] w_maddr;
    logic              w_mwe;
    logic [BYTE_W-1:0] w_wd;
    logic              w_rdy0;
    logic              w_rdy1;
    logic              w_last_beat;
    logic              w_enter;
    logic [1:0]        w_pick;

`ifdef ROUND_ROBIN_EN
    logic              r_last;

    arb_pick u_pick (
        .i_req0 (i_req0),
        .i_req1 (i_req1),
        .i_last (r_last),
        .o_pick (w_pick)
    );
`else
    arb_pick u_pick (
        .i_req0 (i_req0),
        .i_req1 (i_req1),
        .o_pick (w_pick)
    );
`endif

    assign w_last_beat = (r_beat == 2'(BEATS - 1));
    assign w_enter     = (r_state == IDLE) && (w_next != IDLE);

    // next-state: grant from IDLE, leave OWNx on final beat or dropped request
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_pick[0])      w_next = OWN0;
                else if (w_pick[1]) w_next = OWN1;
            end
            OWN0: if (!i_req0 || (i_mrdy && w_last_beat)) w_next = TURN;
            OWN1: if (!i_req1 || (i_mrdy && w_last_beat)) w_next = TURN;
            TURN: w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // port muxes: only the owner sees MRDY and drives address/data/write enable
    always_comb begin
        w_maddr = r_maddr;
        w_mwe   = 1'b0;
        w_wd    = '0;
        w_rdy0  = 1'b0;
        w_rdy1  = 1'b0;
        case (r_state)
            OWN0: begin
                w_maddr = i_addr0;
                w_mwe   = i_we0;
                w_wd    = i_wd0;
                w_rdy0  = i_mrdy;
            end
            OWN1: begin
                w_maddr = i_addr1;
                w_mwe   = i_we1;
                w_wd    = i_wd1;
                w_rdy1  = i_mrdy;
            end
            default: ;
        endcase
    end

    // state, grants, held address, beat counter and last-grant pointer
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= IDLE;
            r_gnt0  <= 1'b0;
            r_gnt1  <= 1'b0;
            r_maddr <= '0;
            r_beat  <= '0;
`ifdef ROUND_ROBIN_EN
            r_last  <= 1'b1;
`endif
        end else begin
            r_state <= w_next;
            r_gnt0  <= (w_next == OWN0);
            r_gnt1  <= (w_next == OWN1);
            r_maddr <= w_maddr;
            if (w_enter) begin
                r_beat <= '0;
            end else if ((r_state == OWN0 || r_state == OWN1) && i_mrdy) begin
                r_beat <= r_beat + 2'd1;
            end
`ifdef ROUND_ROBIN_EN
            if (w_enter) r_last <= (w_next == OWN1);
`endif
        end
    end

    assign o_gnt0  = r_gnt0;
    assign o_gnt1  = r_gnt1;
    assign o_rdy0  = w_rdy0;
    assign o_rdy1  = w_rdy1;
    assign o_maddr = w_maddr;
    assign o_mwe   = w_mwe;
    assign io_md   = w_mwe ? w_wd : {BYTE_W{1'bz}};
    assign o_rd    = io_md;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios followed by
// random traffic, all compared cycle by cycle against a transaction-level
// model of ownership, beats and turnaround.
module tb_mem_port_arbiter;
    import cpu_mem_pkg::*;

    logic              clk = 1'b0;
    logic              rst, req0, req1, we0, we1, mrdy;
    logic [ADDR_W-1:0] addr0, addr1, maddr;
    logic [BYTE_W-1:0] wd0, wd1, mem_byte, rd;
    logic              gnt0, gnt1, rdy0, rdy1, mwe;
    wire  [BYTE_W-1:0] md;

    // memory side drives the bus whenever the arbiter is not writing
    assign md = mwe ? 8'bzzzzzzzz : mem_byte;

    mem_port_arbiter dut (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_req0  (req0),
        .i_req1  (req1),
        .i_addr0 (addr0),
        .i_addr1 (addr1),
        .i_we0   (we0),
        .i_we1   (we1),
        .i_wd0   (wd0),
        .i_wd1   (wd1),
        .o_gnt0  (gnt0),
        .o_gnt1  (gnt1),
        .o_rdy0  (rdy0),
        .o_rdy1  (rdy1),
        .o_rd    (rd),
        .o_maddr (maddr),
        .o_mwe   (mwe),
        .io_md   (md),
        .i_mrdy  (mrdy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // model: owner -1 = free, 0/1 = requester, 2 = turnaround bubble
    int              m_owner = -1;
    int              m_beats = 0;
    int              m_last  = 1;
    logic [31:0]     m_maddr = '0;
    bit              m_valid = 0;

    bit              pend0 = 0, pend1 = 0, reraise0 = 0;
    int              cyc_n = 0;
    int              rdy0_cnt = 0, rdy1_cnt = 0;
    int              grant_q[$];
    logic [7:0]      rd_q[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // entered at a negedge with inputs set; checks outputs, clocks, advances model
    task automatic step();
        logic        e_mwe;
        logic [31:0] e_maddr;
        logic [7:0]  e_rd;
        int          prev, win;
        #1;
        if (m_valid) begin
            e_mwe   = (m_owner == 0) ? we0 : (m_owner == 1) ? we1 : 1'b0;
            e_maddr = (m_owner == 0) ? addr0 : (m_owner == 1) ? addr1 : m_maddr;
            e_rd    = e_mwe ? ((m_owner == 0) ? wd0 : wd1) : mem_byte;
            chk("gnt0",  32'(gnt0),  32'(m_owner == 0));
            chk("gnt1",  32'(gnt1),  32'(m_owner == 1));
            chk("rdy0",  32'(rdy0),  32'(m_owner == 0 && mrdy));
            chk("rdy1",  32'(rdy1),  32'(m_owner == 1 && mrdy));
            chk("mwe",   32'(mwe),   32'(e_mwe));
            chk("maddr", maddr,      e_maddr);
            chk("rd",    32'(rd),    32'(e_rd));
        end
        if (rdy0) rdy0_cnt++;
        if (rdy1) begin
            rdy1_cnt++;
            rd_q.push_back(rd);
        end
        @(posedge clk);
        prev = m_owner;
        if (rst) begin
            m_owner = -1;
            m_beats = 0;
            m_last  = 1;
            m_maddr = '0;
            m_valid = 1;
        end else begin
            if (m_owner == 0)      m_maddr = addr0;
            else if (m_owner == 1) m_maddr = addr1;
            case (m_owner)
                2: m_owner = -1;
                -1: begin
                    win = -1;
                    if (req0 && req1) begin
`ifdef ROUND_ROBIN_EN
                        win = (m_last == 0) ? 1 : 0;
`else
                        win = 0;
`endif
                    end else if (req0) win = 0;
                    else if (req1)     win = 1;
                    if (win >= 0) begin
                        m_owner = win;
                        m_beats = 0;
                        m_last  = win;
                    end
                end
                default: begin
                    if (!((m_owner == 0) ? req0 : req1)) m_owner = 2;
                    else if (mrdy) begin
                        m_beats++;
                        if (m_beats == BEATS) m_owner = 2;
                    end
                end
            endcase
        end
        if (prev == -1 && (m_owner == 0 || m_owner == 1)) grant_q.push_back(m_owner);
        if (prev == 0 && m_owner == 2) begin
            if (reraise0) reraise0 = 0;
            else          pend0 = 0;
        end
        if (prev == 1 && m_owner == 2) pend1 = 0;
        cyc_n++;
        @(negedge clk);
    endtask

    task automatic cyc(input logic mrdy_v);
        req0 = pend0;
        req1 = pend1;
        mrdy = mrdy_v;
        step();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        pend0 = 0;
        pend1 = 0;
        reraise0 = 0;
        cyc(1'b0);
        rst = 1'b0;
    endtask

    logic [7:0] rbytes [4];
    int drop_cyc, gnt_cyc;

    initial begin
        rbytes[0] = 8'hDE; rbytes[1] = 8'hAD; rbytes[2] = 8'hBE; rbytes[3] = 8'hEF;
        rst = 1'b1; req0 = 0; req1 = 0; we0 = 0; we1 = 0; mrdy = 0;
        addr0 = '0; addr1 = '0; wd0 = '0; wd1 = '0; mem_byte = 8'h00;
        step();
        do_reset();

        // write burst from requester 0 at 0x100
        pend0 = 1; we0 = 1; rdy0_cnt = 0; rdy1_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            addr0 = 32'h100 + 32'(m_beats);
            wd0 = 8'($urandom);
            mem_byte = 8'($urandom);
            cyc(1'b1);
        end
        chk("t1_rdy0_cnt", 32'(rdy0_cnt), 32'd4);
        chk("t1_rdy1_cnt", 32'(rdy1_cnt), 32'd0);
        chk("t1_maddr_hold", maddr, 32'h103);

        // simultaneous requests twice in a row
        do_reset();
        we0 = 0; grant_q.delete();
        pend0 = 1; pend1 = 1; reraise0 = 1;
        for (int i = 0; i < 24; i++) cyc(1'b1);
        chk("t2_ngrants", 32'(grant_q.size()), 32'd3);
`ifdef ROUND_ROBIN_EN
        chk("t2_order", {29'd0, 1'(grant_q[0]), 1'(grant_q[1]), 1'(grant_q[2])}, 32'b010);
`else
        chk("t2_order", {29'd0, 1'(grant_q[0]), 1'(grant_q[1]), 1'(grant_q[2])}, 32'b001);
`endif

        // requester 1 read of 0x40
        do_reset();
        pend1 = 1; addr1 = 32'h40; we1 = 0; rd_q.delete(); rdy0_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            mem_byte = (m_owner == 1) ? rbytes[m_beats & 3] : 8'($urandom);
            cyc(1'b1);
        end
        chk("t3_nbytes", 32'(rd_q.size()), 32'd4);
        if (rd_q.size() == 4) chk("t3_rd_word", {rd_q[0], rd_q[1], rd_q[2], rd_q[3]}, 32'hDEADBEEF);
        chk("t3_rdy0_cnt", 32'(rdy0_cnt), 32'd0);

        // requester 0 aborts after two beats with requester 1 waiting
        do_reset();
        pend0 = 1; we0 = 1; rdy0_cnt = 0; drop_cyc = -1; gnt_cyc = -1;
        for (int i = 0; i < 12; i++) begin
            if (gnt1 && gnt_cyc < 0) gnt_cyc = cyc_n;
            if (i == 1) pend1 = 1;
            addr0 = 32'h200 + 32'(m_beats);
            wd0 = 8'($urandom);
            if (m_owner == 0 && m_beats == 2 && drop_cyc < 0) begin
                pend0 = 0;
                drop_cyc = cyc_n;
                cyc(1'b0);
            end else begin
                cyc(1'b1);
            end
        end
        chk("t4_rdy0_cnt", 32'(rdy0_cnt), 32'd2);
        chk("t4_gnt1_gap", 32'(gnt_cyc - drop_cyc), 32'd3);

        // reset during beat 3 of a requester 1 write
        do_reset();
        pend1 = 1; we1 = 1; wd1 = 8'hC3; addr1 = 32'h80;
        for (int i = 0; i < 6 && !(m_owner == 1 && m_beats == 2); i++) cyc(1'b1);
        chk("t5_in_beat3", 32'(m_owner == 1 && m_beats == 2), 32'd1);
        rst = 1'b1;
        cyc(1'b1);
        rst = 1'b0; pend1 = 0; req1 = 0; mrdy = 1; mem_byte = 8'h5A;
        #1;
        chk("t5_gnt1", 32'(gnt1), 32'd0);
        chk("t5_mwe", 32'(mwe), 32'd0);
        chk("t5_md_free", 32'(rd), 32'h5A);
        chk("t5_rdy1", 32'(rdy1), 32'd0);
        chk("t5_maddr", maddr, 32'd0);
        @(negedge clk);
        we1 = 0;

        // spurious MRDY while idle, then a full transaction
        for (int i = 0; i < 3; i++) cyc(1'b1);
        pend0 = 1; we0 = 0; rdy0_cnt = 0;
        for (int i = 0; i < 10; i++) cyc(1'b1);
        chk("t6_rdy0_cnt", 32'(rdy0_cnt), 32'd4);

        // random traffic
        do_reset();
        for (int i = 0; i < 2000; i++) begin
            if (!pend0 && ($urandom % 4) == 0) pend0 = 1;
            if (!pend1 && ($urandom % 4) == 0) pend1 = 1;
            if (pend0 && ($urandom % 20) == 0) pend0 = 0;
            if (pend1 && ($urandom % 20) == 0) pend1 = 0;
            addr0 = $urandom; addr1 = $urandom;
            wd0 = 8'($urandom); wd1 = 8'($urandom);
            we0 = 1'($urandom); we1 = 1'b0;
            mem_byte = 8'($urandom);
            if (($urandom % 300) == 0) begin
                do_reset();
            end else begin
                cyc(1'($urandom));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
